// File: rtl/hydra_pkg.sv
// Shared switch definitions: default geometry, page pointer and queue id types.
package hydra_pkg;

  localparam int NUM_PORTS_DEF = 16;
  localparam int NUM_PRIO_DEF  = 8;
  localparam int PTR_W_DEF     = 16;
  localparam int PORT_W_DEF    = $clog2(NUM_PORTS_DEF);
  localparam int PRIO_W_DEF    = $clog2(NUM_PRIO_DEF);

  typedef logic [PTR_W_DEF-1:0]             page_ptr_t;
  typedef logic [PORT_W_DEF+PRIO_W_DEF-1:0] qid_t;

  function automatic qid_t qid(input logic [PORT_W_DEF-1:0] port,
                               input logic [PRIO_W_DEF-1:0] prio);
    return {port, prio};
  endfunction

endpackage

// File: rtl/queue_linker_if.sv
// Enqueue/dequeue/occupancy bus between the write controller, read scheduler and queue_linker.
interface queue_linker_if #(
  parameter int NUM_PORTS = hydra_pkg::NUM_PORTS_DEF,
  parameter int NUM_PRIO  = hydra_pkg::NUM_PRIO_DEF,
  parameter int PTR_W     = hydra_pkg::PTR_W_DEF
) ();

  localparam int PORT_W = $clog2(NUM_PORTS);
  localparam int PRIO_W = $clog2(NUM_PRIO);
  localparam int NQ     = NUM_PORTS * NUM_PRIO;

  logic              enq_vld;
  logic [PORT_W-1:0] enq_port;
  logic [PRIO_W-1:0] enq_prio;
  logic [PTR_W-1:0]  enq_ptr;
  logic              deq_req;
  logic [PORT_W-1:0] deq_port;
  logic [PRIO_W-1:0] deq_prio;
  logic              deq_vld;
  logic [PTR_W-1:0]  deq_ptr;
  logic              deq_err;
  logic [NQ-1:0]     q_empty;
  logic [PORT_W-1:0] len_port;
  logic [PRIO_W-1:0] len_prio;
  logic [PTR_W:0]    len_out;

  modport master (
    output enq_vld, enq_port, enq_prio, enq_ptr,
    output deq_req, deq_port, deq_prio,
    output len_port, len_prio,
    input  deq_vld, deq_ptr, deq_err, q_empty, len_out
  );

  modport slave (
    input  enq_vld, enq_port, enq_prio, enq_ptr,
    input  deq_req, deq_port, deq_prio,
    input  len_port, len_prio,
    output deq_vld, deq_ptr, deq_err, q_empty, len_out
  );

endinterface

// File: rtl/queue_linker_jump_table.sv
// Page next-pointer store: one synchronous write port, one asynchronous read port.
module jump_table #(
  parameter int PTR_W = 16,
  parameter int DEPTH = 2**PTR_W
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  logic [PTR_W-1:0] wdata,
  input  logic [PTR_W-1:0] raddr,
  output logic [PTR_W-1:0] rdata
);

  logic [PTR_W-1:0] mem [DEPTH];

  // Link write; contents are never cleared since every entry is written before it is followed.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/queue_linker.sv
// Per-(port, priority) linked-list page queue manager. Define QUEUE_LEN_EN for per-queue occupancy counters.
module queue_linker
  import hydra_pkg::*;
#(
  parameter int NUM_PORTS = NUM_PORTS_DEF,
  parameter int NUM_PRIO  = NUM_PRIO_DEF,
  parameter int PTR_W     = PTR_W_DEF,
  parameter int PAGES     = 2**PTR_W
) (
  input logic         clk,
  input logic         rst,
  queue_linker_if.slave bus
);

  localparam int PORT_W = $clog2(NUM_PORTS);
  localparam int PRIO_W = $clog2(NUM_PRIO);
  localparam int QW     = PORT_W + PRIO_W;
  localparam int NQ     = NUM_PORTS * NUM_PRIO;

  logic [PTR_W-1:0] head_r [NQ];
  logic [PTR_W-1:0] tail_r [NQ];
  logic [NQ-1:0]    empty_r;
  logic             deq_vld_r;
  logic             deq_err_r;
  logic [PTR_W-1:0] deq_ptr_r;

  logic [QW-1:0]    qe_s;
  logic [QW-1:0]    qd_s;
  logic             deq_ok_s;
  logic             deq_last_s;
  logic             enq_init_s;
  logic             jump_we_s;
  logic [PTR_W-1:0] jump_rdata_s;

  assign qe_s = {bus.enq_port, bus.enq_prio};
  assign qd_s = {bus.deq_port, bus.deq_prio};

  // A same-queue dequeue of the last entry hands the queue over to the incoming page.
  always_comb begin
    deq_ok_s   = bus.deq_req & ~empty_r[qd_s];
    deq_last_s = deq_ok_s & (head_r[qd_s] == tail_r[qd_s]);
    enq_init_s = bus.enq_vld & (empty_r[qe_s] | (deq_last_s & (qd_s == qe_s)));
    jump_we_s  = bus.enq_vld & ~empty_r[qe_s] & ~rst;
  end

  jump_table #(
    .PTR_W (PTR_W),
    .DEPTH (PAGES)
  ) u_jump_table (
    .clk   (clk),
    .we    (jump_we_s),
    .waddr (tail_r[qe_s]),
    .wdata (bus.enq_ptr),
    .raddr (head_r[qd_s]),
    .rdata (jump_rdata_s)
  );

  // Queue state and registered dequeue response; the enqueue is applied after the dequeue so it wins on head/empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int q = 0; q < NQ; q++) begin
        head_r[q] <= '0;
        tail_r[q] <= '0;
      end
      empty_r   <= '1;
      deq_vld_r <= 1'b0;
      deq_err_r <= 1'b0;
      deq_ptr_r <= '0;
    end else begin
      deq_vld_r <= deq_ok_s;
      deq_err_r <= bus.deq_req & empty_r[qd_s];
      if (deq_ok_s) begin
        deq_ptr_r <= head_r[qd_s];
        if (deq_last_s) begin
          empty_r[qd_s] <= 1'b1;
        end else begin
          head_r[qd_s] <= jump_rdata_s;
        end
      end
      if (bus.enq_vld) begin
        tail_r[qe_s] <= bus.enq_ptr;
        if (enq_init_s) begin
          head_r[qe_s]  <= bus.enq_ptr;
          empty_r[qe_s] <= 1'b0;
        end
      end
    end
  end

  assign bus.deq_vld = deq_vld_r;
  assign bus.deq_err = deq_err_r;
  assign bus.deq_ptr = deq_ptr_r;
  assign bus.q_empty = empty_r;

`ifdef QUEUE_LEN_EN
  localparam logic [PTR_W:0] LEN_MAX = (PTR_W+1)'(PAGES);

  logic [PTR_W:0] len_r [NQ];
  logic           len_inc_s;
  logic           len_dec_s;

  // Enqueue and successful dequeue on the same queue cancel out.
  always_comb begin
    len_inc_s = bus.enq_vld & ~(deq_ok_s & (qd_s == qe_s));
    len_dec_s = deq_ok_s & ~(bus.enq_vld & (qd_s == qe_s));
  end

  // Saturating occupancy counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int q = 0; q < NQ; q++) begin
        len_r[q] <= '0;
      end
    end else begin
      if (len_dec_s && (len_r[qd_s] != '0)) begin
        len_r[qd_s] <= len_r[qd_s] - 1'b1;
      end
      if (len_inc_s && (len_r[qe_s] != LEN_MAX)) begin
        len_r[qe_s] <= len_r[qe_s] + 1'b1;
      end
    end
  end

  assign bus.len_out = len_r[{bus.len_port, bus.len_prio}];
`else
  assign bus.len_out = '0;
`endif

endmodule

// File: tb/tb_queue_linker.sv
// Self-checking bench for queue_linker: directed scenarios plus randomized traffic against a queue-of-queues model.
module tb_queue_linker;
  import hydra_pkg::*;

  localparam int NP = 16;
  localparam int NR = 8;
  localparam int NQ = NP * NR;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  queue_linker_if #(.NUM_PORTS(NP), .NUM_PRIO(NR), .PTR_W(16)) bus ();

  queue_linker #(.NUM_PORTS(NP), .NUM_PRIO(NR), .PTR_W(16), .PAGES(65536)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [15:0] mq [NQ][$];
  bit          in_use [65536];

  bit          chk_en = 1'b0;
  logic        exp_vld;
  logic        exp_err;
  logic [15:0] exp_ptr;
  logic [NQ-1:0] exp_empty;
  logic [16:0] exp_len;
  int          lq_port = 0;
  int          lq_prio = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of every output against the model's post-edge expectation.
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("deq_vld", 32'(bus.deq_vld), 32'(exp_vld));
      check("deq_err", 32'(bus.deq_err), 32'(exp_err));
      check("deq_ptr", 32'(bus.deq_ptr), 32'(exp_ptr));
      check("len_out", 32'(bus.len_out), 32'(exp_len));
      checks++;
      if (bus.q_empty !== exp_empty) begin
        errors++;
        $display("FAIL q_empty: got %h expected %h at %0t", bus.q_empty, exp_empty, $time);
      end
    end
  end

  task automatic step(input bit r, input bit e, input int ep, input int epr, input logic [15:0] eptr,
                      input bit d, input int dp, input int dpr);
    int qe;
    int qd;
    rst          = r;
    bus.enq_vld  = e;
    bus.enq_port = 4'(ep);
    bus.enq_prio = 3'(epr);
    bus.enq_ptr  = eptr;
    bus.deq_req  = d;
    bus.deq_port = 4'(dp);
    bus.deq_prio = 3'(dpr);
    bus.len_port = 4'(lq_port);
    bus.len_prio = 3'(lq_prio);
    qe = ep * NR + epr;
    qd = dp * NR + dpr;
    exp_vld = 1'b0;
    exp_err = 1'b0;
    if (r) begin
      for (int q = 0; q < NQ; q++) mq[q].delete();
      for (int i = 0; i < 65536; i++) in_use[i] = 1'b0;
      exp_ptr = 16'h0000;
    end else begin
      if (d) begin
        if (mq[qd].size() > 0) begin
          exp_vld = 1'b1;
          exp_ptr = mq[qd].pop_front();
          in_use[exp_ptr] = 1'b0;
        end else begin
          exp_err = 1'b1;
        end
      end
      if (e) begin
        mq[qe].push_back(eptr);
        in_use[eptr] = 1'b1;
      end
    end
    for (int q = 0; q < NQ; q++) exp_empty[q] = (mq[q].size() == 0);
`ifdef QUEUE_LEN_EN
    exp_len = 17'(mq[lq_port * NR + lq_prio].size());
`else
    exp_len = 17'd0;
`endif
    chk_en = 1'b1;
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 0, 0, 16'h0000, 1'b0, 0, 0);
  endtask

  task automatic enq(input int p, input int pr, input logic [15:0] ptr);
    step(1'b0, 1'b1, p, pr, ptr, 1'b0, 0, 0);
  endtask

  task automatic deq(input int p, input int pr);
    step(1'b0, 1'b0, 0, 0, 16'h0000, 1'b1, p, pr);
  endtask

  initial begin
    logic [15:0] rp;
    bit          found;
    logic [NQ-1:0] all_ones;
    all_ones = '1;

    step(1'b1, 1'b0, 0, 0, 16'h0000, 1'b0, 0, 0);
    step(1'b1, 1'b0, 0, 0, 16'h0000, 1'b0, 0, 0);
    check("reset_empty", 32'(bus.q_empty == all_ones), 32'd1);

    // Single entry in and out.
    enq(3, 2, 16'h0010);
    check("t1_not_empty", 32'(bus.q_empty[26]), 32'd0);
    deq(3, 2);
    check("t1_vld", 32'(bus.deq_vld), 32'd1);
    check("t1_ptr", 32'(bus.deq_ptr), 32'h0010);
    check("t1_empty", 32'(bus.q_empty[26]), 32'd1);

    // FIFO order through the jump table, then an underflow.
    enq(5, 0, 16'h0100);
    enq(5, 0, 16'h0205);
    enq(5, 0, 16'h0333);
    deq(5, 0);
    check("t2_ptr0", 32'(bus.deq_ptr), 32'h0100);
    deq(5, 0);
    check("t2_ptr1", 32'(bus.deq_ptr), 32'h0205);
    deq(5, 0);
    check("t2_ptr2", 32'(bus.deq_ptr), 32'h0333);
    deq(5, 0);
    check("t2_err", 32'(bus.deq_err), 32'd1);
    check("t2_novld", 32'(bus.deq_vld), 32'd0);
    check("t2_hold", 32'(bus.deq_ptr), 32'h0333);

    // One-entry queue with simultaneous enqueue and dequeue.
    enq(1, 7, 16'h0042);
    step(1'b0, 1'b1, 1, 7, 16'h0043, 1'b1, 1, 7);
    check("t3_ptr", 32'(bus.deq_ptr), 32'h0042);
    check("t3_not_empty", 32'(bus.q_empty[15]), 32'd0);
    deq(1, 7);
    check("t3_ptr2", 32'(bus.deq_ptr), 32'h0043);
    check("t3_empty", 32'(bus.q_empty[15]), 32'd1);

    // Empty queue with simultaneous enqueue and dequeue: no bypass.
    step(1'b0, 1'b1, 0, 0, 16'h0007, 1'b1, 0, 0);
    check("t4_err", 32'(bus.deq_err), 32'd1);
    deq(0, 0);
    check("t4_vld", 32'(bus.deq_vld), 32'd1);
    check("t4_ptr", 32'(bus.deq_ptr), 32'h0007);

    // Interleaved queues keep their own pointers.
    lq_port = 2;
    lq_prio = 1;
    for (int i = 0; i < 6; i++) begin
      enq(2, 1, 16'(16'h1000 + 2 * i));
      enq(9, 4, 16'(16'h1001 + 2 * i));
    end
`ifdef QUEUE_LEN_EN
    check("t5_len_peak", 32'(bus.len_out), 32'd6);
`endif
    for (int i = 0; i < 6; i++) begin
      deq(2, 1);
      check("t5_ptr_a", 32'(bus.deq_ptr), 32'(16'h1000 + 2 * i));
      deq(9, 4);
      check("t5_ptr_b", 32'(bus.deq_ptr), 32'(16'h1001 + 2 * i));
    end
    check("t5_len_end", 32'(bus.len_out), 32'd0);

    // Reset mid-stream drops the in-flight dequeue.
    lq_port = 4;
    lq_prio = 4;
    for (int i = 0; i < 4; i++) enq(4, 4, 16'(16'h2000 + i));
    step(1'b1, 1'b0, 0, 0, 16'h0000, 1'b1, 4, 4);
    check("t6_novld", 32'(bus.deq_vld), 32'd0);
    check("t6_empty", 32'(bus.q_empty == all_ones), 32'd1);
    check("t6_len", 32'(bus.len_out), 32'd0);
    deq(4, 4);
    check("t6_err", 32'(bus.deq_err), 32'd1);

    // Randomized traffic concentrated on a few queues so they fill and drain.
    for (int c = 0; c < 3000; c++) begin
      int  ep;
      int  epr;
      int  dp;
      int  dpr;
      bit  e;
      bit  d;
      bit  r;
      ep  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NP - 1)) : int'($urandom_range(0, 2));
      epr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NR - 1)) : int'($urandom_range(0, 1));
      dp  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NP - 1)) : int'($urandom_range(0, 2));
      dpr = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NR - 1)) : int'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 0) begin
        dp  = ep;
        dpr = epr;
      end
      lq_port = int'($urandom_range(0, 2));
      lq_prio = int'($urandom_range(0, 1));
      e = ($urandom_range(0, 9) < 6);
      d = ($urandom_range(0, 1) == 1);
      r = ($urandom_range(0, 399) == 0);
      found = 1'b0;
      rp = 16'h0000;
      for (int t = 0; t < 64 && !found; t++) begin
        rp = 16'($urandom);
        found = !in_use[rp];
      end
      step(r, e && found, ep, epr, rp, d, dp, dpr);
    end

    idle();
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
